// File: rtl/fp_fma_narrow.sv
// Narrows a full-width fixed-point FMA sum back to Q(ibits).(fbits) with round-half-to-even
// and saturation, through an elastic two-stage valid/acknowledge pipeline.
module fp_fma_narrow #(
    parameter int unsigned ibits    = 12,
    parameter int unsigned fbits    = 20,
    parameter int unsigned id_bits  = 8,
    parameter int unsigned cnt_bits = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2*(ibits+fbits):0] r,
    input  logic                     r_is_signed,
    input  logic [id_bits-1:0]       iid,
    input  logic                     ivalid,
    output logic                     iacknowledge,
    output logic [ibits+fbits-1:0]   q,
    output logic                     qsat,
    output logic [id_bits-1:0]       oid,
    output logic                     ovalid,
    input  logic                     oacknowledge,
    output logic [cnt_bits-1:0]      sat_count,
    input  logic                     sat_clear
);
    localparam int unsigned W  = ibits + fbits;
    localparam int unsigned XW = 2 * W + 2;  // r plus one sign/zero extension bit
    localparam int unsigned NW = XW - fbits;

    logic                s1_valid_q;
    logic                s1_signed_q;
    logic [NW-1:0]       s1_val_q;
    logic [id_bits-1:0]  s1_id_q;
    logic                s2_valid_q;
    logic                s2_sat_q;
    logic [W-1:0]        s2_data_q;
    logic [id_bits-1:0]  s2_id_q;
    logic [cnt_bits-1:0] sat_count_q;

    logic                s1_advance;
    logic [XW-1:0]       r_ext;
    logic                round_up;
    logic [NW-1:0]       rounded;
    logic [W-1:0]        sat_data;
    logic                sat_flag;

    assign s1_advance   = !s2_valid_q || oacknowledge;
    assign iacknowledge = ivalid && (!s1_valid_q || s1_advance);

    // Guard set and (sticky or odd lsb) gives half-to-even for either sign in two's complement.
    always_comb begin
        r_ext    = {r_is_signed & r[XW-2], r};
        round_up = r_ext[fbits-1] & ((|r_ext[fbits-2:0]) | r_ext[fbits]);
        rounded  = r_ext[XW-1:fbits] + NW'(round_up);
    end

    always_comb begin
        sat_data = s1_val_q[W-1:0];
        sat_flag = 1'b0;
        if (s1_signed_q) begin
            // In range only when every bit from W-1 upward matches the sign.
            if (!(&s1_val_q[NW-1:W-1]) && (|s1_val_q[NW-1:W-1])) begin
                sat_flag = 1'b1;
                sat_data = s1_val_q[NW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end else if (|s1_val_q[NW-1:W]) begin
            sat_flag = 1'b1;
            sat_data = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            if (iacknowledge) begin
                s1_valid_q <= 1'b1;
            end else if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sat_q <= sat_flag;
                end
            end

            if (sat_clear) begin
                sat_count_q <= '0;
            end else if (s2_valid_q && oacknowledge && s2_sat_q && !(&sat_count_q)) begin
                sat_count_q <= sat_count_q + cnt_bits'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (iacknowledge) begin
            s1_val_q    <= rounded;
            s1_signed_q <= r_is_signed;
            s1_id_q     <= iid;
        end
        if (s1_advance && s1_valid_q) begin
            s2_data_q <= sat_data;
            s2_id_q   <= s1_id_q;
        end
    end

    assign q         = s2_data_q;
    assign qsat      = s2_sat_q;
    assign oid       = s2_id_q;
    assign ovalid    = s2_valid_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fp_fma_narrow.sv
// Bench for fp_fma_narrow: directed vectors with literal expectations plus a
// scoreboard driven by an arithmetic rounding/clamping model.
module tb_fp_fma_narrow;
    localparam int unsigned IB = 12;
    localparam int unsigned FB = 20;
    localparam int unsigned W  = IB + FB;

    logic          clock = 1'b0;
    logic          reset;
    logic [2*W:0]  r;
    logic          r_is_signed;
    logic [7:0]    iid;
    logic          ivalid;
    logic          iacknowledge;
    logic [W-1:0]  q;
    logic          qsat;
    logic [7:0]    oid;
    logic          ovalid;
    logic          oacknowledge;
    logic [15:0]   sat_count;
    logic          sat_clear;

    fp_fma_narrow #(
        .ibits   (IB),
        .fbits   (FB),
        .id_bits (8),
        .cnt_bits(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .r           (r),
        .r_is_signed (r_is_signed),
        .iid         (iid),
        .ivalid      (ivalid),
        .iacknowledge(iacknowledge),
        .q           (q),
        .qsat        (qsat),
        .oid         (oid),
        .ovalid      (ovalid),
        .oacknowledge(oacknowledge),
        .sat_count   (sat_count),
        .sat_clear   (sat_clear)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] q;
        logic         sat;
        logic [7:0]   id;
    } exp_t;

    exp_t       model_q[$];
    logic [7:0] arrived[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         sat_exp  = 0;
    bit         checking = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Exact rounding by floor division and remainder, then clamp against the format range.
    function automatic logic [W:0] model(input logic [2*W:0] rv, input logic sgn);
        logic signed [127:0] v, fl, rem, lo, hi;
        v   = sgn ? {{63{rv[2*W]}}, rv} : {63'b0, rv};
        fl  = v >>> FB;
        rem = v - (fl <<< FB);
        if (rem > 128'sd524288 || (rem == 128'sd524288 && fl[0])) fl = fl + 128'sd1;
        if (sgn) begin
            lo = -(128'sd1 <<< (W - 1));
            hi = (128'sd1 <<< (W - 1)) - 128'sd1;
        end else begin
            lo = 128'sd0;
            hi = (128'sd1 <<< W) - 128'sd1;
        end
        if (fl > hi) return {1'b1, hi[W-1:0]};
        if (fl < lo) return {1'b1, lo[W-1:0]};
        return {1'b0, fl[W-1:0]};
    endfunction

    // Scoreboard: sampled on the falling edge, when inputs and state are settled.
    always @(negedge clock) begin
        if (checking) begin
            if (!reset) begin
                model_q.delete();
                sat_exp = 0;
            end else begin
                int   occ;
                logic m;
                exp_t e;
                logic [W:0] mr;
                occ = model_q.size();
                chk("sat_count", sat_count, sat_exp);
                if (occ == 0) chk("ovalid_empty", ovalid, 1'b0);
                if (occ >= 2) chk("ovalid_full", ovalid, 1'b1);
                chk("iacknowledge", iacknowledge,
                    ivalid && (occ < 2 || (occ == 2 && oacknowledge)));
                if (ovalid) begin
                    if (occ == 0) begin
                        chk("spurious_output", 1'b1, 1'b0);
                    end else begin
                        e = model_q[0];
                        chk("q", q, e.q);
                        chk("qsat", qsat, e.sat);
                        chk("oid", oid, e.id);
                    end
                end
                m = 1'b0;
                if (ovalid && oacknowledge && occ > 0) begin
                    e = model_q.pop_front();
                    arrived.push_back(e.id);
                    m = e.sat;
                end
                if (sat_clear) sat_exp = 0;
                else if (m && sat_exp != 65535) sat_exp = sat_exp + 1;
                if (ivalid && iacknowledge) begin
                    mr = model(r, r_is_signed);
                    e.q = mr[W-1:0];
                    e.sat = mr[W];
                    e.id = iid;
                    model_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_check(input logic [2*W:0] rv, input logic sgn, input logic [7:0] id,
                              input logic [W-1:0] eq, input logic es, input string nm,
                              input bit check_lat);
        bit got;
        chk({nm, "_model"}, model(rv, sgn), {es, eq});
        oacknowledge = 1'b1;
        r = rv;
        r_is_signed = sgn;
        iid = id;
        ivalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            got = iacknowledge;
            step();
        end
        ivalid = 1'b0;
        if (!got) chk({nm, "_accept_timeout"}, 1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (ovalid) begin
                got = 1'b1;
                chk({nm, "_q"}, q, eq);
                chk({nm, "_qsat"}, qsat, es);
                chk({nm, "_oid"}, oid, id);
                if (check_lat) chk({nm, "_latency"}, i, 1);
            end
        end
        if (!got) chk({nm, "_output_timeout"}, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W:0] v;
        logic [2*W:0] rr;
        int           next_id;
        int           accepts;
        bit           got;

        reset = 1'b0;
        ivalid = 1'b0;
        oacknowledge = 1'b0;
        sat_clear = 1'b0;
        r = '0;
        r_is_signed = 1'b1;
        iid = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        checking = 1'b1;
        @(negedge clock);
        chk("reset_ovalid", ovalid, 1'b0);
        chk("reset_qsat", qsat, 1'b0);
        chk("reset_sat_count", sat_count, 16'd0);
        chk("reset_iack_idle", iacknowledge, 1'b0);
        step();

        // Exact value and two-cycle latency
        v = 65'd3 << 40;
        send_check(v, 1'b1, 8'h11, 32'h0030_0000, 1'b0, "exact", 1'b1);

        // Ties and near-ties
        send_check(65'h8_0000, 1'b1, 8'h21, 32'h0, 1'b0, "tie_even0", 1'b0);
        send_check(65'h18_0000, 1'b1, 8'h22, 32'h2, 1'b0, "tie_odd1", 1'b0);
        send_check(65'h8_0001, 1'b1, 8'h23, 32'h1, 1'b0, "above_half", 1'b0);
        v = -65'h8_0000;
        send_check(v, 1'b1, 8'h24, 32'h0, 1'b0, "tie_neg", 1'b0);

        // Signed saturation
        v = 65'd5000 << 40;
        send_check(v, 1'b1, 8'h31, 32'h7FFF_FFFF, 1'b1, "sat_pos", 1'b0);
        v = -(65'd5000 << 40);
        send_check(v, 1'b1, 8'h32, 32'h8000_0000, 1'b1, "sat_neg", 1'b0);
        @(negedge clock);
        chk("sat_count_after_signed", sat_count, 16'd2);
        step();

        // Unsigned saturation, including carry out of the rounding into bit W
        v = 65'd5000 << 40;
        send_check(v, 1'b0, 8'h41, 32'hFFFF_FFFF, 1'b1, "usat", 1'b0);
        v = (65'hFFFF_FFFF << 20) | 65'hF_FFFF;
        send_check(v, 1'b0, 8'h42, 32'hFFFF_FFFF, 1'b1, "usat_carry", 1'b0);
        v = 65'h7_FFFF;
        send_check(v, 1'b0, 8'h43, 32'h0, 1'b0, "u_below_half", 1'b0);
        @(negedge clock);
        chk("sat_count_after_unsigned", sat_count, 16'd4);
        step();

        // Backpressure: ids 1..6, downstream stalled for the first 5 cycles
        arrived.delete();
        next_id = 1;
        accepts = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            oacknowledge = (cyc >= 5);
            ivalid = (next_id <= 6);
            iid = 8'(next_id);
            r = 65'(next_id) << 20;
            r_is_signed = 1'b1;
            @(negedge clock);
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_hold_ovalid", ovalid, 1'b1);
                chk("bp_hold_oid", oid, 8'd1);
                chk("bp_hold_q", q, 32'd1);
            end
            if (ivalid && iacknowledge) begin
                next_id++;
                accepts++;
            end
            if (cyc == 4) chk("bp_accepts_while_stalled", accepts, 2);
            step();
        end
        ivalid = 1'b0;
        chk("bp_all_sent", next_id, 7);
        chk("bp_arrived_count", arrived.size(), 6);
        for (int i = 0; i < 6 && i < arrived.size(); i++) chk("bp_order", arrived[i], 8'(i + 1));

        // Random traffic against the scoreboard
        for (int k = 0; k < 80; k++) begin
            oacknowledge = ($urandom_range(0, 3) != 0);
            ivalid = $urandom_range(0, 1);
            r_is_signed = $urandom_range(0, 1);
            rr = 65'({$urandom, $urandom, $urandom});
            r = 65'($signed(rr) >>> $urandom_range(0, 44));
            if ($urandom_range(0, 3) == 0) r[19:0] = 20'h8_0000;
            iid = 8'($urandom);
            step();
        end
        ivalid = 1'b0;
        oacknowledge = 1'b1;
        repeat (4) step();

        // Reset with both stages holding saturated results
        oacknowledge = 1'b0;
        ivalid = 1'b1;
        r_is_signed = 1'b1;
        r = 65'd5000 << 40;
        iid = 8'h51;
        repeat (3) step();
        ivalid = 1'b0;
        @(negedge clock);
        chk("pre_reset_full", ovalid, 1'b1);
        step();
        reset = 1'b0;
        oacknowledge = 1'b1;
        step();
        reset = 1'b1;
        oacknowledge = 1'b0;
        @(negedge clock);
        chk("midreset_ovalid", ovalid, 1'b0);
        chk("midreset_sat_count", sat_count, 16'd0);
        chk("midreset_qsat", qsat, 1'b0);
        step();

        // sat_clear wins over a simultaneous saturated acknowledge
        v = 65'd5000 << 40;
        send_check(v, 1'b1, 8'h61, 32'h7FFF_FFFF, 1'b1, "pre_clear", 1'b0);
        @(negedge clock);
        chk("count_before_clear", sat_count, 16'd1);
        step();
        oacknowledge = 1'b0;
        ivalid = 1'b1;
        iid = 8'h62;
        r = v;
        step();
        ivalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            got = ovalid;
            step();
        end
        if (!got) chk("clear_wait_timeout", 1'b1, 1'b0);
        oacknowledge = 1'b1;
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        oacknowledge = 1'b0;
        @(negedge clock);
        chk("clear_wins", sat_count, 16'd0);
        chk("clear_drained", ovalid, 1'b0);
        step();

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
